led_cmd_ctrl: RTL and testbench
===============================

LED_CMD_CTRL -- requirements
Module: led_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000000, giving the argument-wait limit in clk cycles (1 s at 100 MHz).
REQ-002 SHALL have parameter LED_RESET, default 8'h00, giving the led value after reset.
REQ-003 clk  input  1  100 MHz system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx_data  input  8  received byte, valid only while rx_new=1.
REQ-006 rx_new  input  1  one-cycle strobe marking a new received byte.
REQ-007 tx_busy  input  1  serial transmitter busy; a new byte may only be offered while 0.
REQ-008 tx_data  output  8  reply byte, held stable whenever tx_new=1.
REQ-009 tx_new  output  1  one-cycle strobe requesting transmission of tx_data.
REQ-010 led  output  8  registered LED drive value.
REQ-011 overrun  output  1  sticky flag: a received byte was dropped.

Function
REQ-012 States SHALL be IDLE, GET_ARG, SEND, GUARD.
REQ-013 IDLE, rx_new=1, rx_data=8'h57 ('W'): SHALL clear the timeout counter and go to GET_ARG.
REQ-014 IDLE, rx_new=1, rx_data=8'h52 ('R'): SHALL load the reply register with led and go to SEND.
REQ-015 IDLE, rx_new=1, any other byte: SHALL load the reply with 8'h3F ('?') and go to SEND.
REQ-016 GET_ARG, rx_new=1: SHALL write rx_data to led on that edge, load the reply with 8'h4B ('K'), and go to SEND.
REQ-017 GET_ARG, no byte: the counter SHALL increment each cycle. When it reaches TIMEOUT_CYCLES-1 without a byte, the block SHALL load the reply with '?' and go to SEND, leaving led unchanged.
REQ-018 GET_ARG, rx_new=1 in the same cycle as the timeout: the byte SHALL win and REQ-016 SHALL apply.
REQ-019 SEND, tx_busy=0: SHALL assert tx_new for exactly one cycle with tx_data equal to the reply, then go to GUARD.
REQ-020 SEND, tx_busy=1: SHALL hold, with tx_new=0.
REQ-021 GUARD: SHALL stay exactly one cycle, then go to IDLE. This guarantees at least 2 cycles between tx_new pulses.
REQ-022 rx_new=1 while in SEND or GUARD: the byte SHALL be dropped, overrun SHALL be set, and the state SHALL be unaffected.
REQ-023 overrun SHALL clear only on reset.
REQ-024 tx_new SHALL be 0 in every state other than the single SEND exit cycle.
REQ-025 led SHALL change only per REQ-016; it SHALL be registered with no combinational path from rx_data.
REQ-026 Latency: an rx_new in IDLE or GET_ARG with tx_busy=0 SHALL produce tx_new exactly 1 cycle later.
REQ-027 The timeout counter SHALL be ceil(log2(TIMEOUT_CYCLES)) bits wide and SHALL saturate rather than wrap.

Reset
REQ-028 On rst=1, regardless of clk, the block SHALL immediately enter IDLE with led=LED_RESET, tx_new=0, tx_data=8'h00, overrun=0 and counter=0.
REQ-029 Reset asserted mid-command (GET_ARG, SEND or GUARD) SHALL abort the command, with no tx_new pulse and no led write.
REQ-030 Release of rst SHALL be taken as already synchronized to clk by the upstream reset conditioner.

Structure
REQ-031 Command and reply byte constants ('W', 'R', 'K', '?') and the state encoding SHALL live in the shared package/header led_cmd_pkg.
REQ-032 The timeout counter SHALL be one sub-module, cmd_timeout, with clear, enable and expired ports, reusable by later command blocks.
REQ-033 The block SHALL be instantiated between the top-level UART RX/TX modules and the led port.

Verification
REQ-034 Reset, then rx 'W', then 8'hA5 five cycles later -> led=8'hA5 on the edge after the second byte; one tx_new with tx_data=8'h4B.
REQ-035 led=8'h3C, rx 'R', tx_busy=0 -> tx_new exactly 1 cycle after rx_new with tx_data=8'h3C; led unchanged.
REQ-036 rx 8'h00, then 'W' with TIMEOUT_CYCLES=16 and no argument -> two replies, both '?'; the second tx_new occurs 16 cycles after the 'W' strobe; led unchanged.
REQ-037 rx 'R' with tx_busy=1 for 50 cycles -> no tx_new for 50 cycles, one tx_new in the cycle tx_busy falls. A second rx_new during that wait -> overrun=1, still exactly one reply.
REQ-038 rx 'W', then rst pulsed for 1 cycle mid-GET_ARG, then rx 8'hFF -> led=LED_RESET, no tx_new from the aborted command, and 8'hFF treated as an unknown command giving reply '?'.
REQ-039 rx_new coincident with timeout expiry, rx_data=8'h81 -> led=8'h81 and reply 'K', not '?'.

Source files
------------

// File: rtl/led_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_cmd_pkg
// Purpose : Command/reply byte constants and state encoding for led_cmd_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
package led_cmd_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR   = 8'h3F;  // '?'

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_GET_ARG = 2'd1;
    localparam state_t ST_SEND    = 2'd2;
    localparam state_t ST_GUARD   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/cmd_timeout.sv
`default_nettype none
// ============================================================================
// Module  : cmd_timeout
// Purpose : Saturating wait counter; expired flags the step onto TIMEOUT_CYCLES-1.
// Revision: 1.0 - initial release
// ============================================================================
module cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES >= 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fires in the cycle whose closing edge brings the count to TIMEOUT_CYCLES-1.
    assign expired = enable && !clear && (cnt_q >= CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/led_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : led_cmd_ctrl
// Purpose : UART byte command decoder: 'W' <arg> writes led, 'R' reads it back.
// Revision: 1.0 - initial release
// ============================================================================
module led_cmd_ctrl
    import led_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 100000000,
    parameter logic [7:0] LED_RESET      = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_new,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_new,
    output logic [7:0] led,
    output logic       overrun
);

    state_t     state_q,   state_d;
    logic [7:0] led_q,     led_d;
    logic [7:0] reply_q,   reply_d;
    logic       overrun_q, overrun_d;
    logic       tmo_clear;
    logic       tmo_enable;
    logic       tmo_expired;

    cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            led_q     <= LED_RESET;
            reply_q   <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            reply_q   <= reply_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        reply_d    = reply_q;
        overrun_d  = overrun_q;
        tmo_clear  = 1'b0;
        tmo_enable = (state_q == ST_GET_ARG);
        case (state_q)
            ST_IDLE: begin
                if (rx_new) begin
                    if (rx_data == CMD_WRITE) begin
                        tmo_clear = 1'b1;
                        state_d   = ST_GET_ARG;
                    end else if (rx_data == CMD_READ) begin
                        reply_d = led_q;
                        state_d = ST_SEND;
                    end else begin
                        reply_d = RSP_ERR;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_GET_ARG: begin
                // A byte arriving in the expiry cycle takes priority over the timeout.
                if (rx_new) begin
                    led_d   = rx_data;
                    reply_d = RSP_OK;
                    state_d = ST_SEND;
                end else if (tmo_expired) begin
                    reply_d = RSP_ERR;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (rx_new) begin
                    overrun_d = 1'b1;
                end
                if (!tx_busy) begin
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (rx_new) begin
                    overrun_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_new = (state_q == ST_SEND) && !tx_busy;
    end

    assign tx_data = reply_q;
    assign led     = led_q;
    assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_led_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_cmd_ctrl
// Purpose : Directed self-checking bench for led_cmd_ctrl (TIMEOUT_CYCLES=16).
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_cmd_ctrl;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_new  = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_new;
    logic [7:0] led;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    int         cyc           = 0;
    int         tx_count      = 0;
    int         last_tx_cycle = -1;
    logic [7:0] last_tx_data  = 8'h00;

    led_cmd_ctrl #(
        .TIMEOUT_CYCLES(16),
        .LED_RESET     (8'h00)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx_data(rx_data),
        .rx_new (rx_new),
        .tx_busy(tx_busy),
        .tx_data(tx_data),
        .tx_new (tx_new),
        .led    (led),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_new) begin
            tx_count      <= tx_count + 1;
            last_tx_cycle <= cyc;
            last_tx_data  <= tx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int strobe);
        rx_data = b;
        rx_new  = 1'b1;
        strobe  = cyc;
        tick(1);
        rx_new  = 1'b0;
        rx_data = 8'h00;
    endtask

    int base;
    int s;
    int sw;
    int cf;

    initial begin
        // Asynchronous reset takes effect before any clock edge.
        #2;
        check("rst_led", led, 8'h00);
        check("rst_tx_new", tx_new, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_overrun", overrun, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // Write command with argument five cycles after 'W'.
        base = tx_count;
        send_byte(8'h57, sw);
        check("w_led_unchanged", led, 8'h00);
        tick(4);
        send_byte(8'hA5, s);
        check("w_led_a5", led, 8'hA5);
        tick(3);
        check("w_reply_count", tx_count, base + 1);
        check("w_reply_data", last_tx_data, 8'h4B);
        check("w_reply_latency", last_tx_cycle, s + 1);

        // Read back after setting led=3C.
        send_byte(8'h57, s);
        tick(1);
        send_byte(8'h3C, s);
        tick(3);
        base = tx_count;
        send_byte(8'h52, s);
        tick(3);
        check("r_reply_count", tx_count, base + 1);
        check("r_reply_data", last_tx_data, 8'h3C);
        check("r_reply_latency", last_tx_cycle, s + 1);
        check("r_led_unchanged", led, 8'h3C);

        // Unknown byte, then a write that times out.
        base = tx_count;
        send_byte(8'h00, s);
        tick(3);
        check("unk_reply_count", tx_count, base + 1);
        check("unk_reply_data", last_tx_data, 8'h3F);
        check("unk_reply_latency", last_tx_cycle, s + 1);
        send_byte(8'h57, sw);
        tick(25);
        check("tmo_reply_count", tx_count, base + 2);
        check("tmo_reply_data", last_tx_data, 8'h3F);
        check("tmo_reply_cycle", last_tx_cycle, sw + 16);
        check("tmo_led_unchanged", led, 8'h3C);

        // Read held off by tx_busy for 50 cycles, with a dropped byte meanwhile.
        tx_busy = 1'b1;
        base = tx_count;
        send_byte(8'h52, s);
        check("busy_no_overrun_yet", overrun, 1'b0);
        tick(9);
        send_byte(8'h57, sw);
        check("busy_overrun_set", overrun, 1'b1);
        tick(39);
        check("busy_no_tx", tx_count, base);
        tx_busy = 1'b0;
        cf = cyc;
        tick(4);
        check("busy_reply_count", tx_count, base + 1);
        check("busy_reply_cycle", last_tx_cycle, cf);
        check("busy_reply_data", last_tx_data, 8'h3C);
        check("busy_overrun_sticky", overrun, 1'b1);
        check("busy_led_unchanged", led, 8'h3C);

        // Reset pulse in the middle of GET_ARG aborts the write.
        base = tx_count;
        send_byte(8'h57, sw);
        tick(3);
        rst = 1'b1;
        #1;
        check("abort_led_reset", led, 8'h00);
        check("abort_overrun_clr", overrun, 1'b0);
        check("abort_tx_data", tx_data, 8'h00);
        tick(1);
        rst = 1'b0;
        tick(3);
        check("abort_no_tx", tx_count, base);
        send_byte(8'hFF, s);
        tick(3);
        check("abort_ff_count", tx_count, base + 1);
        check("abort_ff_data", last_tx_data, 8'h3F);
        check("abort_ff_latency", last_tx_cycle, s + 1);
        check("abort_ff_led", led, 8'h00);

        // Argument arriving in the exact timeout-expiry cycle wins.
        base = tx_count;
        send_byte(8'h57, sw);
        tick(14);
        send_byte(8'h81, s);
        check("race_led", led, 8'h81);
        tick(20);
        check("race_reply_count", tx_count, base + 1);
        check("race_reply_data", last_tx_data, 8'h4B);
        check("race_reply_cycle", last_tx_cycle, sw + 16);
        check("race_overrun_clear", overrun, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
